io_uart_tx: RTL and testbench
=============================

// Module: io_uart_tx
// PURPOSE
//  MMIO transmit-only UART core: responder side of the LSU I/O interface (io_cs/io_rd_en/io_wr_en).
//  Sits on the I/O interconnect in one 0x100-byte MMIO window. Buffers CPU bytes in a FIFO, serialises them 8N1 on uart_tx.
//  Also returns register reads one cycle after the request.
// PARAMETERS
//  FIFO_DEPTH        16    TX byte FIFO entries; power of two, >=2
//  DEFAULT_BAUD_DIV  434   reset value of BAUD_DIV (clocks per bit; 50 MHz / 115200)
// PORTS
//  clk            in   1   core clock
//  rst_n          in   1   asynchronous, active-low reset
//  io_cs          in   1   this core's chip-select from the LSU
//  io_rd_en       in   1   read request, valid when io_cs=1
//  io_wr_en       in   1   write request, valid when io_cs=1
//  io_addr        in   8   byte offset within window (mem_addr[7:0])
//  io_wr_data     in   32  lane-aligned store data
//  io_wr_strobe   in   4   byte enables
//  io_rd_data     out  32  read data
//  io_rd_valid    out  1   read-data strobe
//  uart_tx        out  1   serial line, idle high
//  tx_irq         out  1   level: FIFO empty and shifter idle
// BEHAVIOUR
//  Registers (word offsets; io_addr[1:0] ignored):
//   0x00 TXDATA   W: strobe[0] pushes wr_data[7:0]. R: 0.
//   0x04 STATUS   R: {28'0, overflow, empty, full, busy}. W: strobe[0] & wr_data[3] clears overflow.
//   0x08 BAUD_DIV R/W: [15:0], needs strobe[1:0]=2'b11; value 0 stored as 1.
//   other offsets: reads return 0, writes ignored.
//  Access fires only when io_cs=1. io_rd_en & io_wr_en both 1 with io_cs: write performed, read also answered.
//  Read: io_rd_valid=1 exactly one cycle after io_cs&io_rd_en; io_rd_data registered, 0 when not valid.
//   STATUS reflects state at the request edge.
//  Push: accepted iff !full || pop in the same cycle. Otherwise byte dropped, overflow<=1 (sticky).
//   Same-cycle overflow set and overflow clear: set wins.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE, or STOP -> START when the FIFO is non-empty.
//   IDLE: uart_tx=1; FIFO non-empty -> pop into shift reg, go START.
//   START: uart_tx=0 for BAUD_DIV clocks.
//   DATA: 8 bits, LSB first, BAUD_DIV clocks each; 3-bit index counter.
//   STOP: uart_tx=1 for BAUD_DIV clocks. At its end, pop the next byte if available (back-to-back frames, no idle gap).
//  Baud counter: 16-bit down-counter reloaded with BAUD_DIV-1 at each bit start.
//   BAUD_DIV writes take effect at the next bit start, never mid-bit.
//  Frame length = 10*BAUD_DIV clocks. First start bit begins 1 cycle after the push into an empty FIFO while IDLE.
//  busy = (state != IDLE). tx_irq = empty && !busy.
//  Reset (async assert, sync-deassert handled externally): output values
//   uart_tx=1, io_rd_valid=0, io_rd_data=0, tx_irq=1.
//   Internal: FIFO empty, overflow=0, BAUD_DIV=DEFAULT_BAUD_DIV, state=IDLE.
//   Reset mid-frame aborts the frame; line returns high immediately.
//  FIFO pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits to distinguish full from empty.
// STRUCTURE
//  Shared package (defines): uart_tx_state_e {IDLE,START,DATA,STOP}, register offset constants UART_TXDATA/STATUS/BAUD_DIV.
//  Shared package (defines): STATUS bit-index constants.
//  Sub-module: sync_fifo #(.DATA_WIDTH(8), .DEPTH(FIFO_DEPTH)): push/pop/full/empty/count, no internal drop logic.
//  Top: register decode, read mux + read-response register, baud counter, FSM, shift register.
// TESTING
//  1. BAUD_DIV=4, write TXDATA=0xA5 -> uart_tx: 0 (4 clk), then 1,0,1,0,0,1,0,1 (4 clk each), then 1 (4 clk); tx_irq 1->0->1.
//  2. Write 3 bytes back-to-back -> three 40-clk frames with no idle gap; STATUS.busy=1 throughout, then 0.
//  3. FIFO_DEPTH=16, BAUD_DIV=434: push 18 bytes fast -> full=1; overflow=1; exactly 17 frames transmitted
//     (first pops immediately); STATUS write 0x8 clears overflow.
//  4. Read STATUS with io_cs=0 -> no io_rd_valid. Read 0x08 after reset -> rd_valid next cycle, rd_data=434.
//     Read 0x0C -> 0.
//  5. Write BAUD_DIV=8 mid-frame with divider 4 -> current bit finishes at 4 clocks, subsequent bits 8 clocks;
//     write 0 -> reads back 1.
//  6. Assert rst_n=0 mid-DATA -> uart_tx=1 same cycle (async); after release FIFO empty, BAUD_DIV=434, tx_irq=1.

Source files
------------

// File: rtl/io_uart_tx_pkg.sv
// Shared definitions for the io_uart_tx MMIO transmit UART.
//   - uart_tx_state_e : serialiser FSM states
//   - UART_*          : register byte offsets within the 0x100-byte window
//   - STATUS_*_BIT    : bit positions inside the STATUS register
//   - baud_sanitize   : maps a written divider of 0 to 1
package io_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  localparam logic [7:0] UART_TXDATA   = 8'h00;
  localparam logic [7:0] UART_STATUS   = 8'h04;
  localparam logic [7:0] UART_BAUD_DIV = 8'h08;

  localparam int STATUS_BUSY_BIT     = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_EMPTY_BIT    = 2;
  localparam int STATUS_OVERFLOW_BIT = 3;

  // A zero divider would make every bit zero clocks long; clamp it to 1.
  function automatic logic [15:0] baud_sanitize(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (pointers/count only)
//   push_i        : write push_data_i; caller guarantees !full_o || pop_i
//   push_data_i   : write data
//   pop_i         : advance read pointer; caller guarantees !empty_o
//   pop_data_o    : head-of-queue data (valid while !empty_o)
//   full_o/empty_o: occupancy flags
//   count_o       : number of stored entries (one extra bit so full != empty)
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DATA_WIDTH-1:0]    push_data_i,
  input  logic                     pop_i,
  output logic [DATA_WIDTH-1:0]    pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/io_uart_tx.sv
// MMIO transmit-only UART (8N1) on the LSU I/O interface.
// Ports:
//   clk, rst_n      : core clock, asynchronous active-low reset
//   io_cs           : chip-select for this core's window
//   io_rd_en/wr_en  : read / write request (qualified by io_cs)
//   io_addr         : byte offset in window; [1:0] ignored
//   io_wr_data      : store data; io_wr_strobe : byte enables
//   io_rd_data      : registered read data, 0 when io_rd_valid=0
//   io_rd_valid     : high one cycle after an accepted read
//   uart_tx         : serial line, idle high
//   tx_irq          : level, FIFO empty and serialiser idle
// Registers: 0x00 TXDATA (W push), 0x04 STATUS {overflow,empty,full,busy},
//            0x08 BAUD_DIV [15:0] (clocks per bit).
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH       = 16,
  parameter int DEFAULT_BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_cs,
  input  logic        io_rd_en,
  input  logic        io_wr_en,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_wr_data,
  input  logic [3:0]  io_wr_strobe,
  output logic [31:0] io_rd_data,
  output logic        io_rd_valid,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RST = 16'(DEFAULT_BAUD_DIV);

  logic [7:0]       reg_off;
  logic             wr_fire, rd_fire;
  logic             push_req, push, pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_rd_data;
  logic [CNT_W-1:0] fifo_count_unused;
  logic             ovf_clear;

  logic             overflow_q, overflow_d;
  logic [15:0]      baud_div_q, baud_div_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [3:0]       status;

  uart_tx_state_e   state_q;
  logic [15:0]      baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy, bit_end;
  logic             unused_ok;

  // Register decode
  assign reg_off   = {io_addr[7:2], 2'b00};
  assign wr_fire   = io_cs & io_wr_en;
  assign rd_fire   = io_cs & io_rd_en;
  assign push_req  = wr_fire && (reg_off == UART_TXDATA) && io_wr_strobe[0];
  assign ovf_clear = wr_fire && (reg_off == UART_STATUS) && io_wr_strobe[0]
                     && io_wr_data[STATUS_OVERFLOW_BIT];

  assign busy    = (state_q != IDLE);
  assign bit_end = (baud_cnt_q == 16'd0);

  // The FSM takes a byte when idle, or at the end of a stop bit so frames
  // run back to back. A push into a full FIFO still fits if a pop happens
  // in the same cycle.
  assign pop  = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign push = push_req && (!fifo_full || pop);

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (io_wr_data[7:0]),
    .pop_i       (pop),
    .pop_data_o  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_unused)
  );

  always_comb begin
    status                      = '0;
    status[STATUS_BUSY_BIT]     = busy;
    status[STATUS_FULL_BIT]     = fifo_full;
    status[STATUS_EMPTY_BIT]    = fifo_empty;
    status[STATUS_OVERFLOW_BIT] = overflow_q;
  end

  // Control registers; a dropped push in the same cycle as a clear wins.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clear)           overflow_d = 1'b0;
    if (push_req && !push)   overflow_d = 1'b1;
    baud_div_d = baud_div_q;
    if (wr_fire && (reg_off == UART_BAUD_DIV) && (io_wr_strobe[1:0] == 2'b11))
      baud_div_d = baud_sanitize(io_wr_data[15:0]);
  end

  // Read response reflects register state at the request edge.
  always_comb begin
    rd_valid_d = rd_fire;
    rd_data_d  = '0;
    if (rd_fire) begin
      case (reg_off)
        UART_STATUS:   rd_data_d[3:0]  = status;
        UART_BAUD_DIV: rd_data_d[15:0] = baud_div_q;
        default:       rd_data_d       = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      baud_div_q <= BAUD_RST;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      baud_div_q <= baud_div_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Serialiser: every bit start reloads the counter from the current
  // divider, so divider writes only affect bits that start afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q    <= START;
            shift_q    <= fifo_rd_data;
            baud_cnt_q <= baud_div_q - 16'd1;
            tx_q       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q    <= DATA;
            bit_idx_q  <= '0;
            baud_cnt_q <= baud_div_q - 16'd1;
            tx_q       <= shift_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt_q <= baud_div_q - 16'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              state_q    <= START;
              shift_q    <= fifo_rd_data;
              baud_cnt_q <= baud_div_q - 16'd1;
              tx_q       <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx     = tx_q;
  assign tx_irq      = fifo_empty && !busy;
  assign io_rd_data  = rd_data_q;
  assign io_rd_valid = rd_valid_q;

  assign unused_ok = ^{io_addr[1:0], io_wr_data[31:16], io_wr_strobe[3:2], fifo_count_unused};

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx.
module tb_io_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_cs = 1'b0, io_rd_en = 1'b0, io_wr_en = 1'b0;
  logic [7:0]  io_addr = '0;
  logic [31:0] io_wr_data = '0;
  logic [3:0]  io_wr_strobe = '0;
  logic [31:0] io_rd_data;
  logic        io_rd_valid, uart_tx, tx_irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  io_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_BAUD_DIV(434)) dut (
    .clk(clk), .rst_n(rst_n), .io_cs(io_cs), .io_rd_en(io_rd_en), .io_wr_en(io_wr_en),
    .io_addr(io_addr), .io_wr_data(io_wr_data), .io_wr_strobe(io_wr_strobe),
    .io_rd_data(io_rd_data), .io_rd_valid(io_rd_valid), .uart_tx(uart_tx), .tx_irq(tx_irq)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 99000) begin
      $display("FAIL watchdog: cycles=%0d limit=99000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  // Line receiver at divider 434, used by the overflow scenario.
  localparam int RX_DIV = 434;
  bit         rx_en = 1'b0;
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_ferr = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (!rx_en) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (uart_tx == 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      for (int k = 0; k < 8; k++)
        if (rx_cnt == RX_DIV * (k + 1) + RX_DIV / 2) rx_sh <= {uart_tx, rx_sh[7:1]};
      if (rx_cnt == RX_DIV * 9 + RX_DIV / 2) begin
        if (uart_tx !== 1'b1) rx_ferr <= rx_ferr + 1;
        rx_q.push_back(rx_sh);
        rx_act <= 1'b0;
      end
    end
  end

  task automatic drive_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    io_cs = 1'b1; io_wr_en = 1'b1; io_rd_en = 1'b0; io_addr = a; io_wr_data = d; io_wr_strobe = s;
  endtask

  task automatic drive_rd(input logic cs, input logic [7:0] a);
    io_cs = cs; io_rd_en = 1'b1; io_wr_en = 1'b0; io_addr = a; io_wr_data = '0; io_wr_strobe = '0;
  endtask

  task automatic drive_idle();
    io_cs = 1'b0; io_rd_en = 1'b0; io_wr_en = 1'b0; io_addr = '0; io_wr_data = '0; io_wr_strobe = '0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); drive_wr(a, d, s);
    @(negedge clk); drive_idle();
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
    checks++; if (io_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b want 0", io_rd_valid); end
    checks++; if (io_rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h want 0", io_rd_data); end
    checks++; if (tx_irq !== 1'b1) begin failures++; $display("FAIL reset_tx_irq: got %b want 1", tx_irq); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (uart_tx !== 1'b1 || tx_irq !== 1'b1) begin failures++; $display("FAIL post_reset_idle: tx=%b irq=%b want 1 1", uart_tx, tx_irq); end
  endtask

  task automatic test_reg_read();
    @(negedge clk); drive_rd(1'b0, 8'h04);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b0 || io_rd_data !== 32'h0) begin failures++; $display("FAIL rd_no_cs: valid=%b data=%h want 0 0", io_rd_valid, io_rd_data); end
    drive_rd(1'b1, 8'h08);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'd434) begin failures++; $display("FAIL rd_baud_reset: valid=%b data=%0d want 1 434", io_rd_valid, io_rd_data); end
    @(negedge clk);
    checks++; if (io_rd_valid !== 1'b0 || io_rd_data !== 32'h0) begin failures++; $display("FAIL rd_valid_drop: valid=%b data=%h want 0 0", io_rd_valid, io_rd_data); end
    drive_rd(1'b1, 8'h0C);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'h0) begin failures++; $display("FAIL rd_unmapped: valid=%b data=%h want 1 0", io_rd_valid, io_rd_data); end
    drive_rd(1'b1, 8'h05);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'h4) begin failures++; $display("FAIL rd_status_reset: valid=%b data=%h want 1 4", io_rd_valid, io_rd_data); end
    drive_rd(1'b1, 8'h00);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'h0) begin failures++; $display("FAIL rd_txdata: valid=%b data=%h want 1 0", io_rd_valid, io_rd_data); end
  endtask

  task automatic test_single_frame();
    bus_write(8'h08, 32'd4, 4'b0011);
    for (int n = 0; n < 42; n++) begin
      if (n == 0) drive_wr(8'h00, 32'hA5, 4'b0001);
      else if (n == 1) drive_idle();
      if (n == 1) begin
        checks++; if (uart_tx !== 1'b1 || tx_irq !== 1'b0) begin failures++; $display("FAIL single_pushed: tx=%b irq=%b want 1 0", uart_tx, tx_irq); end
      end
      if (n >= 2) begin
        checks++; if (uart_tx !== frame_bit(8'hA5, (n - 2) / 4)) begin failures++; $display("FAIL single_bit[%0d]: got %b want %b", n - 2, uart_tx, frame_bit(8'hA5, (n - 2) / 4)); end
      end
      if (n == 20) begin
        checks++; if (tx_irq !== 1'b0) begin failures++; $display("FAIL single_irq_mid: got %b want 0", tx_irq); end
      end
      @(negedge clk);
    end
    checks++; if (tx_irq !== 1'b1 || uart_tx !== 1'b1) begin failures++; $display("FAIL single_done: irq=%b tx=%b want 1 1", tx_irq, uart_tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3];
    int s;
    b[0] = 8'h3C; b[1] = 8'h81; b[2] = 8'hF0;
    for (int n = 0; n < 122; n++) begin
      if (n < 3) drive_wr(8'h00, {24'd0, b[n]}, 4'b0001);
      else if (n == 3) drive_idle();
      else if (n % 10 == 6) drive_rd(1'b1, 8'h04);
      else if (n % 10 == 7) begin
        drive_idle();
        checks++; if (io_rd_valid !== 1'b1 || io_rd_data[0] !== 1'b1) begin failures++; $display("FAIL b2b_busy@%0d: valid=%b busy=%b want 1 1", n, io_rd_valid, io_rd_data[0]); end
      end
      if (n >= 2) begin
        s = n - 2;
        checks++; if (uart_tx !== frame_bit(b[s / 40], (s % 40) / 4)) begin failures++; $display("FAIL b2b_bit[%0d]: got %b want %b", s, uart_tx, frame_bit(b[s / 40], (s % 40) / 4)); end
      end
      @(negedge clk);
    end
    drive_rd(1'b1, 8'h04);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'h4) begin failures++; $display("FAIL b2b_status_end: valid=%b data=%h want 1 4", io_rd_valid, io_rd_data); end
    checks++; if (tx_irq !== 1'b1) begin failures++; $display("FAIL b2b_irq_end: got %b want 1", tx_irq); end
  endtask

  task automatic test_baud_change();
    int s, j;
    bus_write(8'h08, 32'd4, 4'b0011);
    for (int n = 0; n < 78; n++) begin
      if (n == 0) drive_wr(8'h00, 32'h55, 4'b0001);
      else if (n == 1 || n == 4) drive_idle();
      else if (n == 3) drive_wr(8'h08, 32'd8, 4'b0011);
      if (n >= 2) begin
        s = n - 2;
        j = (s < 4) ? 0 : 1 + (s - 4) / 8;
        checks++; if (uart_tx !== frame_bit(8'h55, j)) begin failures++; $display("FAIL baud_bit[%0d]: got %b want %b", s, uart_tx, frame_bit(8'h55, j)); end
      end
      @(negedge clk);
    end
    checks++; if (tx_irq !== 1'b1) begin failures++; $display("FAIL baud_done_irq: got %b want 1", tx_irq); end
    bus_write(8'h08, 32'd0, 4'b0011);
    drive_rd(1'b1, 8'h08);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'd1) begin failures++; $display("FAIL baud_zero: valid=%b data=%0d want 1 1", io_rd_valid, io_rd_data); end
    bus_write(8'h08, 32'd4, 4'b0011);
  endtask

  task automatic test_async_reset();
    @(negedge clk); drive_wr(8'h00, 32'h00, 4'b0001);
    @(negedge clk); drive_wr(8'h00, 32'h7E, 4'b0001);
    @(negedge clk); drive_idle();
    repeat (10) @(negedge clk);
    checks++; if (uart_tx !== 1'b0 || tx_irq !== 1'b0) begin failures++; $display("FAIL arst_mid_data: tx=%b irq=%b want 0 0", uart_tx, tx_irq); end
    rst_n = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL arst_line_high: got %b want 1", uart_tx); end
    checks++; if (tx_irq !== 1'b1) begin failures++; $display("FAIL arst_irq: got %b want 1", tx_irq); end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (uart_tx !== 1'b1 || tx_irq !== 1'b1) begin failures++; $display("FAIL arst_stays_idle: tx=%b irq=%b want 1 1", uart_tx, tx_irq); end
    drive_rd(1'b1, 8'h08);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'd434) begin failures++; $display("FAIL arst_baud: valid=%b data=%0d want 1 434", io_rd_valid, io_rd_data); end
    drive_rd(1'b1, 8'h04);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'h4) begin failures++; $display("FAIL arst_status: valid=%b data=%h want 1 4", io_rd_valid, io_rd_data); end
  endtask

  task automatic test_overflow();
    int w, ferr0;
    bus_write(8'h08, 32'd434, 4'b0011);
    ferr0 = rx_ferr;
    rx_en = 1'b1;
    for (int n = 0; n < 19; n++) begin
      if (n < 18) drive_wr(8'h00, 32'h10 + n, 4'b0001);
      else drive_idle();
      @(negedge clk);
    end
    drive_rd(1'b1, 8'h04);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'hB) begin failures++; $display("FAIL ovf_status_full: valid=%b data=%h want 1 b", io_rd_valid, io_rd_data); end
    w = 0;
    while (tx_irq !== 1'b1 && w < 80000) begin
      @(negedge clk);
      w++;
    end
    checks++; if (tx_irq !== 1'b1) begin failures++; $display("FAIL ovf_drain_timeout: irq=%b after %0d cycles want 1", tx_irq, w); end
    checks++; if (rx_q.size() != 17) begin failures++; $display("FAIL ovf_frame_count: got %0d want 17", rx_q.size()); end
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 8'(8'h10 + i)) begin failures++; $display("FAIL ovf_byte[%0d]: got %h want %h", i, rx_q[i], 8'(8'h10 + i)); end
    end
    checks++; if (rx_ferr != ferr0) begin failures++; $display("FAIL ovf_stop_bits: bad=%0d want 0", rx_ferr - ferr0); end
    rx_en = 1'b0;
    drive_rd(1'b1, 8'h04);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'hC) begin failures++; $display("FAIL ovf_sticky: valid=%b data=%h want 1 c", io_rd_valid, io_rd_data); end
    bus_write(8'h04, 32'h8, 4'b0001);
    drive_rd(1'b1, 8'h04);
    @(negedge clk); drive_idle();
    checks++; if (io_rd_valid !== 1'b1 || io_rd_data !== 32'h4) begin failures++; $display("FAIL ovf_clear: valid=%b data=%h want 1 4", io_rd_valid, io_rd_data); end
  endtask

  initial begin
    test_reset();
    test_reg_read();
    test_single_frame();
    test_back_to_back();
    test_baud_change();
    test_async_reset();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
